// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants, record layout and lookup helpers
// for the 16550-style serial receive engine and its receive FIFO.
package uart_rx_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 5;
  localparam int REC_W      = 11;

  // LCR bit positions
  localparam int LCR_WL0 = 0;
  localparam int LCR_WL1 = 1;
  localparam int LCR_STB = 2;
  localparam int LCR_PEN = 3;
  localparam int LCR_EPS = 4;
  localparam int LCR_SP  = 5;

  // FIFO entry field positions
  localparam int REC_DAT = 3;
  localparam int REC_BI  = 2;
  localparam int REC_PE  = 1;
  localparam int REC_FE  = 0;

  // receiver state encodings
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_START  = 4'd1;
  localparam logic [3:0] S_DATA   = 4'd2;
  localparam logic [3:0] S_PARITY = 4'd3;
  localparam logic [3:0] S_STOP   = 4'd4;
  localparam logic [3:0] S_PUSH   = 4'd5;

  typedef struct packed {
    logic [7:0] data;
    logic       bi;
    logic       pe;
    logic       fe;
  } rec_t;

  // Character timeout: four character times in 16x ticks, minus one.
  // Counted in half-bit units so 1.5 stop bits (5-bit words) fit.
  function automatic logic [9:0] toc_val(input logic [3:0] l);
    logic [4:0] hb;
    hb = 5'd14
       + {2'b00, l[1:0], 1'b0}
       + {3'b000, l[3], 1'b0};
    if (l[2])
      hb = hb + ((l[1:0] == 2'b00) ? 5'd1 : 5'd2);
    return {hb, 5'b00000} - 10'd1;
  endfunction

  // Break detect reload: one full frame of ticks, minus one.
  function automatic logic [7:0] brk_val(input logic [3:0] l);
    logic [3:0] fb;
    fb = 4'd7
       + {2'b00, l[1:0]}
       + {3'b000, l[3]}
       + {3'b000, l[2]};
    return {fb, 4'b0000} - 8'd1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16 x 11 first-word-fall-through receive FIFO.
// Ports: clk, wb_rst_i (async, active-high), clr_i (sync clear),
//   push_i/data_i (write), pop_i (discard head), ovr_clr_i (clear
//   overrun), data_o (head), count_o, overrun_o, error_o (any PE/FE/BI).
module uart_rx_fifo
  import uart_rx_pkg::*;
(
  input  logic             clk,
  input  logic             wb_rst_i,
  input  logic             clr_i,
  input  logic             ovr_clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [REC_W-1:0] data_i,
  output logic [REC_W-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             overrun_o,
  output logic             error_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [REC_W-1:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wp_q;
  logic [AW-1:0]         rp_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [FIFO_DEPTH-1:0] err_q;
  logic                  ovr_q;

  logic empty;
  logic full;
  logic do_pop;
  logic do_push;
  logic ovr_set;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop_i && !empty;
  // a pop frees the slot the same cycle, so a full FIFO still accepts
  assign do_push = push_i && (!full || do_pop);
  assign ovr_set = push_i && full && !do_pop;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem_q[i] <= '0;
    end else if (do_push && !clr_i) begin
      mem_q[wp_q] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      err_q <= '0;
    end else if (clr_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      if (do_pop) begin
        rp_q        <= rp_q + 1'b1;
        err_q[rp_q] <= 1'b0;
      end
      // when full, push and pop share a slot; the new entry wins
      if (do_push) begin
        wp_q        <= wp_q + 1'b1;
        err_q[wp_q] <= |data_i[REC_BI:REC_FE];
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i)
      ovr_q <= 1'b0;
    else if (ovr_set)
      ovr_q <= 1'b1;
    else if (clr_i || ovr_clr_i)
      ovr_q <= 1'b0;
  end

  assign data_o    = mem_q[rp_q];
  assign count_o   = cnt_q;
  assign overrun_o = ovr_q;
  assign error_o   = |err_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling serial receiver with break detection,
// character timeout and a 16-entry FWFT receive FIFO.
// Ports: clk, wb_rst_i (async, active-high), lcr (line control),
//   srx_pad_i (serial in), enable (16x tick), rf_pop, rx_reset,
//   lsr_mask; outputs counter_t (timeout), rf_count, rf_data_out
//   (head: data, BI, PE, FE), rf_error_bit, rf_overrun, rstate,
//   rf_push_pulse.
module uart_rx
  import uart_rx_pkg::*;
(
  input  logic             clk,
  input  logic             wb_rst_i,
  input  logic [7:0]       lcr,
  input  logic             rf_pop,
  input  logic             srx_pad_i,
  input  logic             enable,
  input  logic             rx_reset,
  input  logic             lsr_mask,
  output logic [9:0]       counter_t,
  output logic [CNT_W-1:0] rf_count,
  output logic [REC_W-1:0] rf_data_out,
  output logic             rf_error_bit,
  output logic             rf_overrun,
  output logic [3:0]       rstate,
  output logic             rf_push_pulse
);

  logic [1:0] sync_q;
  logic       rx;

  logic [3:0] rstate_q, rstate_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bidx_q, bidx_d;
  logic [7:0] data_q, data_d;
  logic       pe_q, pe_d;
  logic       lowall_q, lowall_d;
  logic       armed_q, armed_d;
  logic       pend_q, pend_d;
  logic       push_q, push_d;
  rec_t       rec_q, rec_d;
  logic [7:0] brk_q, brk_d;
  logic       brkdone_q, brkdone_d;
  logic [9:0] tmo_q, tmo_d;

  logic       mid;
  logic       exp_par;
  logic       brk_ev;
  logic [2:0] wl_last;
  logic       unused_lcr;

  assign unused_lcr = ^lcr[7:6];

  // pad input is asynchronous to clk
  assign rx = sync_q[1];

  assign wl_last = 3'd4 + {1'b0, lcr[LCR_WL1:LCR_WL0]};
  assign mid     = enable && (tick_q == 4'd15);
  assign exp_par = lcr[LCR_SP]  ? ~lcr[LCR_EPS] :
                   lcr[LCR_EPS] ? ^data_q : ~^data_q;
  assign brk_ev  = enable && !rx && (brk_q == 8'd1) && !brkdone_q;

  always_comb begin
    rstate_d  = rstate_q;
    tick_d    = enable ? tick_q + 4'd1 : tick_q;
    bidx_d    = bidx_q;
    data_d    = data_q;
    pe_d      = pe_q;
    lowall_d  = lowall_q & ~rx;
    armed_d   = armed_q;
    pend_d    = pend_q;
    push_d    = 1'b0;
    rec_d     = rec_q;
    brk_d     = brk_q;
    brkdone_d = brkdone_q;

    unique case (rstate_q)
      S_IDLE: begin
        tick_d = '0;
        if (rx)
          armed_d = 1'b1;
        // an all-low frame is held back until we know if it is a break
        if (pend_q && rx) begin
          pend_d   = 1'b0;
          push_d   = 1'b1;
          rec_d    = '{data: data_q, bi: 1'b0, pe: pe_q, fe: 1'b1};
          rstate_d = S_PUSH;
        end else if (!rx && armed_q && !pend_q) begin
          data_d   = '0;
          bidx_d   = '0;
          pe_d     = 1'b0;
          lowall_d = 1'b1;
          rstate_d = S_START;
        end
      end
      S_START: begin
        if (enable && tick_q == 4'd7) begin
          tick_d = '0;
          if (rx) begin
            armed_d  = 1'b1;
            rstate_d = S_IDLE;
          end else begin
            rstate_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (mid) begin
          data_d[bidx_q] = rx;
          bidx_d         = bidx_q + 3'd1;
          if (bidx_q == wl_last)
            rstate_d = lcr[LCR_PEN] ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (mid) begin
          pe_d     = (rx != exp_par);
          rstate_d = S_STOP;
        end
      end
      S_STOP: begin
        if (mid) begin
          if (lowall_d) begin
            pend_d   = 1'b1;
            armed_d  = 1'b0;
            rstate_d = S_IDLE;
          end else begin
            push_d   = 1'b1;
            rec_d    = '{data: data_q, bi: 1'b0, pe: pe_q, fe: ~rx};
            rstate_d = S_PUSH;
          end
        end
      end
      S_PUSH: begin
        armed_d  = rx;
        rstate_d = S_IDLE;
      end
      default: begin
        rstate_d = S_IDLE;
      end
    endcase

    if (rx) begin
      brk_d     = brk_val(lcr[3:0]);
      brkdone_d = 1'b0;
    end else if (enable && brk_q != '0) begin
      brk_d = brk_q - 8'd1;
    end

    // one break entry per low period; it absorbs any held frame
    if (brk_ev) begin
      brkdone_d = 1'b1;
      pend_d    = 1'b0;
      push_d    = 1'b1;
      rec_d     = '{data: 8'h00, bi: 1'b1, pe: 1'b0, fe: 1'b1};
    end
  end

  always_comb begin
    tmo_d = tmo_q;
    if (rf_count == '0 || push_q || rf_pop)
      tmo_d = toc_val(lcr[3:0]);
    else if (enable && tmo_q != '0)
      tmo_d = tmo_q - 10'd1;
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_q    <= 2'b11;
      rstate_q  <= S_IDLE;
      tick_q    <= '0;
      bidx_q    <= '0;
      data_q    <= '0;
      pe_q      <= 1'b0;
      lowall_q  <= 1'b0;
      armed_q   <= 1'b1;
      pend_q    <= 1'b0;
      push_q    <= 1'b0;
      rec_q     <= '0;
      brk_q     <= '1;
      brkdone_q <= 1'b0;
      tmo_q     <= 10'd639;
    end else begin
      sync_q    <= {sync_q[0], srx_pad_i};
      rstate_q  <= rstate_d;
      tick_q    <= tick_d;
      bidx_q    <= bidx_d;
      data_q    <= data_d;
      pe_q      <= pe_d;
      lowall_q  <= lowall_d;
      armed_q   <= armed_d;
      pend_q    <= pend_d;
      push_q    <= push_d;
      rec_q     <= rec_d;
      brk_q     <= brk_d;
      brkdone_q <= brkdone_d;
      tmo_q     <= tmo_d;
    end
  end

  uart_rx_fifo u_fifo (
    .clk       (clk),
    .wb_rst_i  (wb_rst_i),
    .clr_i     (rx_reset),
    .ovr_clr_i (lsr_mask),
    .push_i    (push_q),
    .pop_i     (rf_pop),
    .data_i    (rec_q),
    .data_o    (rf_data_out),
    .count_o   (rf_count),
    .overrun_o (rf_overrun),
    .error_o   (rf_error_bit)
  );

  assign counter_t     = tmo_q;
  assign rstate        = rstate_q;
  assign rf_push_pulse = push_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx; expected FIFO entries
// are queued as characters are sent and compared as they are popped.
module tb_uart_rx;

  logic        clk;
  logic        wb_rst_i;
  logic [7:0]  lcr;
  logic        rf_pop;
  logic        srx_pad_i;
  logic        enable;
  logic        rx_reset;
  logic        lsr_mask;
  logic [9:0]  counter_t;
  logic [4:0]  rf_count;
  logic [10:0] rf_data_out;
  logic        rf_error_bit;
  logic        rf_overrun;
  logic [3:0]  rstate;
  logic        rf_push_pulse;

  uart_rx dut (
    .clk           (clk),
    .wb_rst_i      (wb_rst_i),
    .lcr           (lcr),
    .rf_pop        (rf_pop),
    .srx_pad_i     (srx_pad_i),
    .enable        (enable),
    .rx_reset      (rx_reset),
    .lsr_mask      (lsr_mask),
    .counter_t     (counter_t),
    .rf_count      (rf_count),
    .rf_data_out   (rf_data_out),
    .rf_error_bit  (rf_error_bit),
    .rf_overrun    (rf_overrun),
    .rstate        (rstate),
    .rf_push_pulse (rf_push_pulse)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [10:0] exp_q[$];
  logic        exp_ovr  = 1'b0;
  int          push_cnt = 0;
  int          en_since = 0;
  int          tmo_ticks = 0;
  bit          tmo_seen = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16x tick every 4 clocks, changed just after posedge
  initial begin
    enable = 1'b0;
    forever begin
      repeat (3) begin
        @(posedge clk);
        #1 enable = 1'b0;
      end
      @(posedge clk);
      #1 enable = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (counter_t == 10'd0 && !tmo_seen && push_cnt > 0) begin
      tmo_seen  = 1'b1;
      tmo_ticks = en_since;
    end
    if (rf_push_pulse) begin
      push_cnt = push_cnt + 1;
      en_since = 0;
    end else if (enable) begin
      en_since = en_since + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic bi,
                                     input logic pe, input logic fe);
    return {d, bi, pe, fe};
  endfunction

  function automatic logic par_err(input logic [7:0] l,
                                   input logic [7:0] d,
                                   input logic pb);
    logic e;
    if (l[5]) e = ~l[4];
    else      e = l[4] ? ^d : ~^d;
    return pb != e;
  endfunction

  task automatic expect_push(input logic [10:0] e);
    if (exp_q.size() < 16) exp_q.push_back(e);
    else                   exp_ovr = 1'b1;
  endtask

  task automatic drive_bit(input logic b);
    srx_pad_i = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_char(input logic [7:0] d, input int nb,
                           input logic pen, input logic pbit,
                           input logic sbit);
    drive_bit(1'b0);
    for (int i = 0; i < nb; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(sbit);
    srx_pad_i = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic pop_chk(input string tag);
    logic [10:0] e;
    check({tag, "_sbq"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(tag, 32'(rf_data_out), 32'(e));
    end
    rf_pop = 1'b1;
    @(negedge clk);
    rf_pop = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int         p0;
    wb_rst_i  = 1'b1;
    lcr       = 8'h03;
    rf_pop    = 1'b0;
    srx_pad_i = 1'b1;
    rx_reset  = 1'b0;
    lsr_mask  = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_rstate", 32'(rstate), 32'd0);
    check("rst_count", 32'(rf_count), 32'd0);
    check("rst_data", 32'(rf_data_out), 32'd0);
    check("rst_ovr", 32'(rf_overrun), 32'd0);
    check("rst_err", 32'(rf_error_bit), 32'd0);
    check("rst_push", 32'(rf_push_pulse), 32'd0);
    check("rst_tmo", 32'(counter_t), 32'd639);
    wb_rst_i = 1'b0;
    repeat (8) @(negedge clk);

    // 8N1 character, then character timeout
    send_char(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    expect_push(mk(8'hA5, 1'b0, 1'b0, 1'b0));
    check("a5_pushes", push_cnt, 1);
    check("a5_count", 32'(rf_count), 32'(exp_q.size()));
    check("a5_head", 32'(rf_data_out), 32'(exp_q[0]));
    check("a5_err", 32'(rf_error_bit), 32'd0);
    for (int i = 0; i < 4000 && !tmo_seen; i++) @(negedge clk);
    check("tmo_reached", 32'(tmo_seen), 32'd1);
    check("tmo_ticks", tmo_ticks, 639);
    repeat (40) @(negedge clk);
    check("tmo_sat", 32'(counter_t), 32'd0);
    pop_chk("a5_pop");
    check("tmo_reload", 32'(counter_t), 32'd639);
    check("a5_empty", 32'(rf_count), 32'd0);

    // parity: even with bad bit, even with good bit, stick
    lcr = 8'h1B;
    send_char(8'h01, 8, 1'b1, 1'b0, 1'b1);
    expect_push(mk(8'h01, 1'b0, par_err(lcr, 8'h01, 1'b0), 1'b0));
    check("pe_err", 32'(rf_error_bit), 32'd1);
    pop_chk("pe_head");
    check("pe_count", 32'(rf_count), 32'd0);
    check("pe_errclr", 32'(rf_error_bit), 32'd0);
    send_char(8'h03, 8, 1'b1, 1'b0, 1'b1);
    expect_push(mk(8'h03, 1'b0, par_err(lcr, 8'h03, 1'b0), 1'b0));
    check("pok_err", 32'(rf_error_bit), 32'd0);
    pop_chk("pok_head");
    lcr = 8'h3B;
    send_char(8'h01, 8, 1'b1, 1'b0, 1'b1);
    expect_push(mk(8'h01, 1'b0, par_err(lcr, 8'h01, 1'b0), 1'b0));
    pop_chk("stick_head");

    // 7-bit word: upper bit stores as zero
    lcr = 8'h02;
    send_char(8'hFF, 7, 1'b0, 1'b0, 1'b1);
    expect_push(mk(8'h7F, 1'b0, 1'b0, 1'b0));
    pop_chk("wl7_head");

    // framing error
    lcr = 8'h03;
    send_char(8'h55, 8, 1'b0, 1'b0, 1'b0);
    expect_push(mk(8'h55, 1'b0, 1'b0, 1'b1));
    check("fe_err", 32'(rf_error_bit), 32'd1);
    pop_chk("fe_head");

    // fill past capacity
    for (int i = 0; i < 17; i++) begin
      d = 8'(i * 13 + 7);
      send_char(d, 8, 1'b0, 1'b0, 1'b1);
      expect_push(mk(d, 1'b0, 1'b0, 1'b0));
      if (i == 15) begin
        check("full_count", 32'(rf_count), 32'd16);
        check("full_ovr", 32'(rf_overrun), 32'(exp_ovr));
      end
    end
    check("ovr_count", 32'(rf_count), 32'(exp_q.size()));
    check("ovr_set", 32'(rf_overrun), 32'(exp_ovr));
    lsr_mask = 1'b1;
    @(negedge clk);
    lsr_mask = 1'b0;
    check("ovr_clr", 32'(rf_overrun), 32'd0);
    for (int i = 0; i < 16; i++) pop_chk("ovr_data");
    check("ovr_empty", 32'(rf_count), 32'd0);

    // break: line low for 200 ticks
    p0 = push_cnt;
    srx_pad_i = 1'b0;
    repeat (800) @(negedge clk);
    srx_pad_i = 1'b1;
    repeat (200) @(negedge clk);
    expect_push(mk(8'h00, 1'b1, 1'b0, 1'b1));
    check("brk_pushes", push_cnt - p0, 1);
    check("brk_count", 32'(rf_count), 32'(exp_q.size()));
    check("brk_head", 32'(rf_data_out), 32'(exp_q[0]));
    check("brk_err", 32'(rf_error_bit), 32'd1);
    rx_reset = 1'b1;
    @(negedge clk);
    rx_reset = 1'b0;
    exp_q.delete();
    check("rxr_count", 32'(rf_count), 32'd0);
    check("rxr_err", 32'(rf_error_bit), 32'd0);
    check("end_rstate", 32'(rstate), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
